// File: rtl/dsp_pkg.sv
// Shared widths and opmode bit positions for the pre-adder/multiplier slice.
//   DATA_W     : operand width (A, B, D, pre-adder result)
//   PROD_W     : full unsigned product width
//   OPM_PREADD : opmode bit that routes D+/-B into the B path
//   OPM_SUB    : opmode bit that selects D-B instead of D+B
package dsp_pkg;

  localparam int unsigned DATA_W     = 18;
  localparam int unsigned PROD_W     = 36;
  localparam int unsigned OPM_PREADD = 0;
  localparam int unsigned OPM_SUB    = 1;

endpackage

// File: rtl/preadd_mult_stage_if.sv
// Operand/result bundle of preadd_mult_stage.
//   a_in, b_in, d_in : operands from the upstream A0/B0/D registers
//   opmode           : [OPM_PREADD] pre-adder enable, [OPM_SUB] subtract
//   in_valid         : qualifies operands and opmode this cycle
//   ceb1, cem        : clock enables for the B1/A1 and M stages
//   bcout            : B1-stage value cascaded to the next slice
//   m_out, out_valid : unsigned product A1*B1 and its qualifier
// master drives operands and enables; slave is the DSP slice.
interface preadd_mult_stage_if;
  import dsp_pkg::*;

  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [DATA_W-1:0] d_in;
  logic [1:0]        opmode;
  logic              in_valid;
  logic              ceb1;
  logic              cem;
  logic [DATA_W-1:0] bcout;
  logic [PROD_W-1:0] m_out;
  logic              out_valid;

  modport master (
    output a_in, b_in, d_in, opmode, in_valid, ceb1, cem,
    input  bcout, m_out, out_valid
  );

  modport slave (
    input  a_in, b_in, d_in, opmode, in_valid, ceb1, cem,
    output bcout, m_out, out_valid
  );

endinterface

// File: rtl/pipe_reg_async.sv
// Generic pipeline register with clock enable and asynchronous active-high
// reset, or a plain wire when EN=0.
//   clk   : rising-edge clock
//   reset : asynchronous clear (ignored when bypassed)
//   ce    : capture enable; q holds when low
//   d, q  : WIDTH-bit data in/out
module pipe_reg_async #(
  parameter int unsigned WIDTH = 1,
  parameter bit          EN    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (EN) begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (ce) q <= d;
      end
    end else begin : g_bypass
      // Control inputs have no role in a bypassed stage.
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, reset, ce};
      assign q = d;
    end
  endgenerate

endmodule

// File: rtl/preadd_mult_stage.sv
// B-path pre-adder, optional B1/A1 register stage, 18x18 unsigned multiplier
// and optional M register stage of a DSP slice.
//   B1REG : 1 = registered B1/A1 stage, 0 = combinational bypass
//   MREG  : 1 = registered M stage,     0 = combinational bypass
//   clk   : sole clock
//   reset : asynchronous active-high clear of every register
//   bus   : operand/result bundle (slave side)
module preadd_mult_stage
  import dsp_pkg::*;
#(
  parameter int unsigned B1REG = 1,
  parameter int unsigned MREG  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  preadd_mult_stage_if.slave   bus
);

  logic [DATA_W-1:0] pre;
  logic [DATA_W-1:0] b1;
  logic [DATA_W-1:0] a1;
  logic              v1;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] m;
  logic              vm;

  // Carry/borrow out of the 18-bit add/subtract is discarded.
  always_comb begin
    pre = bus.b_in;
    if (bus.opmode[OPM_PREADD]) begin
      if (bus.opmode[OPM_SUB]) pre = bus.d_in - bus.b_in;
      else                     pre = bus.d_in + bus.b_in;
    end
  end

  // A1, B1 and v1 share one enable so operands and valid stay aligned.
  pipe_reg_async #(.WIDTH(DATA_W), .EN(B1REG != 0)) u_b1 (
    .clk(clk), .reset(reset), .ce(bus.ceb1), .d(pre), .q(b1)
  );

  pipe_reg_async #(.WIDTH(DATA_W), .EN(B1REG != 0)) u_a1 (
    .clk(clk), .reset(reset), .ce(bus.ceb1), .d(bus.a_in), .q(a1)
  );

  pipe_reg_async #(.WIDTH(1), .EN(B1REG != 0)) u_v1 (
    .clk(clk), .reset(reset), .ce(bus.ceb1), .d(bus.in_valid), .q(v1)
  );

  assign prod = PROD_W'(a1) * PROD_W'(b1);

  pipe_reg_async #(.WIDTH(PROD_W), .EN(MREG != 0)) u_m (
    .clk(clk), .reset(reset), .ce(bus.cem), .d(prod), .q(m)
  );

  pipe_reg_async #(.WIDTH(1), .EN(MREG != 0)) u_vm (
    .clk(clk), .reset(reset), .ce(bus.cem), .d(v1), .q(vm)
  );

  assign bus.bcout     = b1;
  assign bus.m_out     = m;
  assign bus.out_valid = vm;

endmodule

// File: tb/tb_preadd_mult_stage.sv
// Directed bench for preadd_mult_stage: a fully registered instance driven
// through a scoreboard of expected B1 and M values, plus a fully bypassed
// instance checked combinationally.
module tb_preadd_mult_stage;
  import dsp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  preadd_mult_stage_if bus_r ();
  preadd_mult_stage_if bus_c ();

  preadd_mult_stage #(.B1REG(1), .MREG(1)) dut_r (
    .clk(clk), .reset(reset), .bus(bus_r.slave)
  );

  preadd_mult_stage #(.B1REG(0), .MREG(0)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] bc_q[$];
  logic [PROD_W-1:0] m_q[$];

  function automatic logic [DATA_W-1:0] ref_pre(
    input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] d, input logic [1:0] op);
    logic [DATA_W:0] t;
    if (!op[0])     t = {1'b0, b};
    else if (op[1]) t = {1'b0, d} - {1'b0, b};
    else            t = {1'b0, d} + {1'b0, b};
    return t[DATA_W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [PROD_W-1:0] obs,
                     input logic [PROD_W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       input logic [DATA_W-1:0] d, input logic [1:0] op,
                       input logic v, input logic ce1, input logic cm);
    bus_r.a_in = a; bus_r.b_in = b; bus_r.d_in = d; bus_r.opmode = op;
    bus_r.in_valid = v; bus_r.ceb1 = ce1; bus_r.cem = cm;
  endtask

  task automatic idle();
    drive('0, '0, '0, 2'b00, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic push_model(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                            input logic [DATA_W-1:0] d, input logic [1:0] op);
    logic [DATA_W-1:0] p;
    p = ref_pre(b, d, op);
    bc_q.push_back(p);
    m_q.push_back(PROD_W'(a) * PROD_W'(p));
  endtask

  // One operand set with literal expectations: bcout after one edge, product after two.
  task automatic run_one(input string tag, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] d,
                         input logic [1:0] op, input logic [DATA_W-1:0] exp_bc,
                         input logic [PROD_W-1:0] exp_m);
    drive(a, b, d, op, 1'b1, 1'b1, 1'b1);
    bc_q.push_back(exp_bc);
    m_q.push_back(exp_m);
    tick();
    chk({tag, "_bcout"}, PROD_W'(bus_r.bcout), PROD_W'(bc_q.pop_front()));
    chk({tag, "_v_early"}, PROD_W'(bus_r.out_valid), '0);
    idle();
    tick();
    chk({tag, "_m"}, bus_r.m_out, m_q.pop_front());
    chk({tag, "_v"}, PROD_W'(bus_r.out_valid), 1);
    tick();
    chk({tag, "_v_drain"}, PROD_W'(bus_r.out_valid), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] ra, rb, rd;
    logic [1:0]        rop;

    reset = 1'b1;
    idle();
    bus_c.a_in = 18'd4; bus_c.b_in = 18'd6; bus_c.d_in = 18'd1;
    bus_c.opmode = 2'b01; bus_c.in_valid = 1'b1; bus_c.ceb1 = 1'b0; bus_c.cem = 1'b0;
    #3;
    chk("rst_m", bus_r.m_out, '0);
    chk("rst_bc", PROD_W'(bus_r.bcout), '0);
    chk("rst_v", PROD_W'(bus_r.out_valid), '0);
    // Bypassed instance follows inputs even under reset.
    chk("byp_rst_m", bus_c.m_out, 36'd28);
    chk("byp_rst_bc", PROD_W'(bus_c.bcout), 7);
    chk("byp_rst_v", PROD_W'(bus_c.out_valid), 1);

    // Reset overrides enables across edges.
    drive(18'd3, 18'd2, 18'd5, 2'b01, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    chk("rst_hold_m", bus_r.m_out, '0);
    chk("rst_hold_v", PROD_W'(bus_r.out_valid), '0);
    reset = 1'b0;
    idle();

    run_one("basic", 18'd3, 18'd2, 18'd5, 2'b01, 18'd7, 36'h15);
    run_one("subwrap", 18'd1, 18'd1, 18'd0, 2'b11, 18'h3FFFF, 36'h3FFFF);
    run_one("maxprod", 18'h3FFFF, 18'h3FFFF, 18'h12345, 2'b00, 18'h3FFFF, 36'hFFFF80001);
    run_one("subpos", 18'd10, 18'd3, 18'd20, 2'b11, 18'd17, 36'd170);
    run_one("op10", 18'd5, 18'd9, 18'd100, 2'b10, 18'd9, 36'd45);

    // Back-to-back stream of random operand sets.
    for (int i = 0; i < 8; i++) begin
      ra = DATA_W'($urandom); rb = DATA_W'($urandom);
      rd = DATA_W'($urandom); rop = 2'($urandom);
      drive(ra, rb, rd, rop, 1'b1, 1'b1, 1'b1);
      push_model(ra, rb, rd, rop);
      tick();
      chk("strm_bc", PROD_W'(bus_r.bcout), PROD_W'(bc_q.pop_front()));
      if (i > 0) begin
        chk("strm_m", bus_r.m_out, m_q.pop_front());
        chk("strm_v", PROD_W'(bus_r.out_valid), 1);
      end
    end
    idle();
    tick();
    chk("strm_m_last", bus_r.m_out, m_q.pop_front());

    // B1 stall: M keeps recapturing the held product; new inputs never appear.
    drive(18'd7, 18'd9, 18'd0, 2'b00, 1'b1, 1'b1, 1'b1);
    push_model(18'd7, 18'd9, 18'd0, 2'b00);
    tick();
    chk("stall_bc0", PROD_W'(bus_r.bcout), PROD_W'(bc_q.pop_front()));
    for (int i = 0; i < 3; i++) begin
      drive(DATA_W'(100 + i), DATA_W'(200 + i), 18'd1, 2'b01, 1'b1, 1'b0, 1'b1);
      tick();
      chk("stall_m", bus_r.m_out, 36'd63);
      chk("stall_v", PROD_W'(bus_r.out_valid), 1);
      chk("stall_bc", PROD_W'(bus_r.bcout), 9);
    end
    void'(m_q.pop_front());

    // M stall: B1 advances, M holds until cem returns.
    drive(18'd11, 18'd4, 18'd2, 2'b01, 1'b1, 1'b1, 1'b0);
    push_model(18'd11, 18'd4, 18'd2, 2'b01);
    tick();
    chk("mstall_bc", PROD_W'(bus_r.bcout), PROD_W'(bc_q.pop_front()));
    chk("mstall_m", bus_r.m_out, 36'd63);
    idle();
    tick();
    chk("mstall_m_new", bus_r.m_out, m_q.pop_front());
    tick();
    chk("mstall_drain", PROD_W'(bus_r.out_valid), '0);

    // Asynchronous reset with both stages holding valid data.
    drive(18'd2, 18'd3, 18'd0, 2'b00, 1'b1, 1'b1, 1'b1);
    tick();
    drive(18'd5, 18'd6, 18'd0, 2'b00, 1'b1, 1'b1, 1'b1);
    tick();
    chk("pre_rst_v", PROD_W'(bus_r.out_valid), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_m", bus_r.m_out, '0);
    chk("arst_bc", PROD_W'(bus_r.bcout), '0);
    chk("arst_v", PROD_W'(bus_r.out_valid), '0);
    bc_q.delete();
    m_q.delete();
    tick();
    reset = 1'b0;
    drive(18'd13, 18'd7, 18'd1, 2'b11, 1'b1, 1'b1, 1'b1);
    push_model(18'd13, 18'd7, 18'd1, 2'b11);
    tick();
    chk("post_rst_bc", PROD_W'(bus_r.bcout), PROD_W'(bc_q.pop_front()));
    idle();
    tick();
    chk("post_rst_m", bus_r.m_out, m_q.pop_front());
    chk("post_rst_v", PROD_W'(bus_r.out_valid), 1);

    // Bypassed instance: same-cycle response without an edge in between.
    @(posedge clk);
    #1;
    bus_c.in_valid = 1'b0;
    #1;
    chk("byp_m", bus_c.m_out, 36'd28);
    chk("byp_v0", PROD_W'(bus_c.out_valid), '0);
    bus_c.opmode = 2'b11; bus_c.d_in = 18'd10; bus_c.in_valid = 1'b1;
    #1;
    chk("byp_sub_m", bus_c.m_out, 36'd16);
    chk("byp_sub_v", PROD_W'(bus_c.out_valid), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/preadd_mult_stage.md
PREADD_MULT_STAGE -- requirements
Module: preadd_mult_stage

Interface
REQ-001 Parameter B1REG, default 1, meaning: 1 = registered pre-adder/A1 stage, 0 = combinational bypass.
REQ-002 Parameter MREG, default 1, meaning: 1 = registered multiplier output, 0 = combinational bypass.
REQ-003 clk  input  1  sole clock; all registers update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset for every register in the block.
REQ-005 a_in  input  18  multiplier operand A, from the upstream A0 register stage.
REQ-006 b_in  input  18  operand B, from the upstream B0 register stage.
REQ-007 d_in  input  18  pre-adder operand D, from the upstream D register stage.
REQ-008 opmode  input  2  bit0 = pre-adder enable, bit1 = subtract.
REQ-009 in_valid  input  1  qualifies a_in/b_in/d_in/opmode for the current cycle.
REQ-010 ceb1  input  1  clock enable for the B1/A1 stage and its valid bit.
REQ-011 cem  input  1  clock enable for the M stage and its valid bit.
REQ-012 bcout  output  18  B1-stage value, cascaded to the next slice.
REQ-013 m_out  output  36  unsigned product A1*B1.
REQ-014 out_valid  output  1  qualifies m_out.

Function
REQ-015 pre = opmode[0] ? (opmode[1] ? d_in - b_in : d_in + b_in) : b_in, truncated modulo 2^18 with carry/borrow discarded.
REQ-016 B1REG=1: on a clk edge with ceb1=1, b1 <= pre, a1 <= a_in, v1 <= in_valid; with ceb1=0, all three hold.
REQ-017 B1REG=0: b1 = pre, a1 = a_in, v1 = in_valid, combinationally.
REQ-018 bcout = b1.
REQ-019 prod = a1 * b1, zero-extended 18x18 unsigned, full 36-bit result, no truncation.
REQ-020 MREG=1: on a clk edge with cem=1, m <= prod, vm <= v1; with cem=0, both hold.
REQ-021 MREG=0: m = prod and vm = v1, combinationally.
REQ-022 m_out = m and out_valid = vm.
REQ-023 Latency from in_valid to out_valid is B1REG+MREG enabled edges; 2 cycles with both CEs held high.
REQ-024 A1 and B1 SHALL always advance together, so operands stay aligned regardless of CE pattern.
REQ-025 Each stage's valid bit SHALL advance only with that stage's data registers; a stalled stage holds its data and valid.
REQ-026 With ceb1=0 and cem=1, the M stage SHALL recapture the held A1*B1 product and the held v1.
REQ-027 opmode changes take effect on the same cycle as the accompanying operands; no opmode register exists in this block.

Reset
REQ-028 While reset=1, b1, a1, m, v1 and vm SHALL be 0 immediately, without waiting for clk.
REQ-029 Reset SHALL override ceb1/cem, and data in flight at reset assertion SHALL be discarded.
REQ-030 On the first clk edge after reset deasserts, registers SHALL resume normal capture per REQ-016/REQ-020.
REQ-031 Bypassed stages hold no state; their outputs follow their inputs even while reset=1.

Structure
REQ-032 Package dsp_pkg SHALL hold DATA_W=18, PROD_W=36, and the opmode bit indices OPM_PREADD=0 and OPM_SUB=1.
REQ-033 One generic sub-module, pipe_reg_async, SHALL be used: parameters WIDTH and EN (bypass when 0), inputs clk/reset/ce/d, output q.
REQ-034 pipe_reg_async SHALL be instantiated for b1, a1, v1, m and vm; the pre-adder and multiplier remain in the top module.

Verification
REQ-035 B1REG=MREG=1, CEs high, a=3, d=5, b=2, opmode=01, in_valid=1 -> two edges later m_out=0x15 and out_valid=1; bcout=7 after the first edge.
REQ-036 Subtract wrap: d=0, b=1, opmode=11, a=1 -> bcout=0x3FFFF, then m_out=0x3FFFF.
REQ-037 Max product: a=b=0x3FFFF, opmode=00 -> m_out=0xFFFF80001.
REQ-038 Stall: after the first edge hold ceb1=0 and cem=1 for 3 cycles while driving new inputs -> m_out stays on the first product and out_valid stays 1; the new inputs never appear.
REQ-039 Assert reset asynchronously between edges with valid data in both stages -> m_out=0, bcout=0 and out_valid=0 before the next clk edge; after release, the next operand set produces its product after 2 edges.
REQ-040 B1REG=MREG=0: a=4, b=6, d=1, opmode=01 -> m_out=28 and out_valid=in_valid in the same cycle with no clk edge.
